// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, constants and helpers for the LED bank arbiter
package led_pkg;

    localparam int LED_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] REQ_USER   = 2'd0;
    localparam logic [1:0] REQ_STATUS = 2'd1;
    localparam logic [1:0] REQ_ALARM  = 2'd2;

    // Highest set bit wins; an all-zero vector maps to REQ_USER and is
    // never used as an owner because callers gate on |req first.
    function automatic logic [1:0] prio_enc(input logic [2:0] r);
        if (r[2]) begin
            return REQ_ALARM;
        end else if (r[1]) begin
            return REQ_STATUS;
        end else begin
            return REQ_USER;
        end
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - free-running blink phase generator
// Ports: clk, reset (sync active-low), phase (toggles every BLINK_DIV cycles, 1 after reset)
module blink_prescaler #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic phase
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - fixed-priority owner arbitration of the LED bank with hold time and blinking
// Ports: clk, reset (sync active-low), req[2:0] (2 highest), pat0/pat1/pat2, blink_en[2:0],
//        grant (one-hot owner or 0), leds (registered drive), busy (high while owned)
module led_bank_arbiter
    import led_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int HOLD_CYC  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [LED_W-1:0] pat0,
    input  logic [LED_W-1:0] pat1,
    input  logic [LED_W-1:0] pat2,
    input  logic [2:0]       blink_en,
    output logic [2:0]       grant,
    output logic [LED_W-1:0] leds,
    output logic             busy
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    state_t          state, state_nxt;
    logic [1:0]      owner, owner_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [1:0]      top_req;
    logic            phase;
    logic            own_nxt;
    logic [LED_W-1:0] pat_sel;
    logic [2:0]      grant_nxt;
    logic [LED_W-1:0] leds_nxt;

    blink_prescaler #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk  (clk),
        .reset(reset),
        .phase(phase)
    );

    assign top_req = prio_enc(req);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = OWN;
                    owner_nxt = top_req;
                    hold_nxt  = '0;
                end
            end
            OWN: begin
                // A voluntary release wins over a pending preemption.
                if (!req[owner]) begin
                    state_nxt = GAP;
                end else if ((top_req > owner) && (hold_cnt == HOLD_LAST)) begin
                    owner_nxt = top_req;
                    hold_nxt  = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt  = hold_cnt + 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so grant and leds appear
    // on the same edge that enters OWN.
    always_comb begin
        pat_sel = '0;
        case (owner_nxt)
            REQ_USER:   pat_sel = pat0;
            REQ_STATUS: pat_sel = pat1;
            REQ_ALARM:  pat_sel = pat2;
            default:    pat_sel = '0;
        endcase
        own_nxt   = (state_nxt == OWN);
        grant_nxt = own_nxt ? (3'b001 << owner_nxt) : 3'b000;
        leds_nxt  = '0;
        if (own_nxt && !(blink_en[owner_nxt] && !phase)) begin
            leds_nxt = pat_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= REQ_USER;
            hold_cnt <= '0;
            grant    <= 3'b000;
            leds     <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            grant    <= grant_nxt;
            leds     <= leds_nxt;
            busy     <= own_nxt;
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - directed table-driven bench for led_bank_arbiter
module tb_led_bank_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [4:0] pat0, pat1, pat2;
    logic [2:0] blink_en;
    logic [2:0] grant;
    logic [4:0] leds;
    logic       busy;

    int passed;
    int total;

    // Reference blink phase: value in effect at the most recent edge.
    int   bm_cnt;
    logic bm_phase;
    logic bm_used;

    led_bank_arbiter #(
        .BLINK_DIV(4),
        .HOLD_CYC (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .pat0    (pat0),
        .pat1    (pat1),
        .pat2    (pat2),
        .blink_en(blink_en),
        .grant   (grant),
        .leds    (leds),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bm_used = bm_phase;
        if (!reset) begin
            bm_cnt   = 0;
            bm_phase = 1'b1;
        end else if (bm_cnt == 3) begin
            bm_cnt   = 0;
            bm_phase = ~bm_phase;
        end else begin
            bm_cnt = bm_cnt + 1;
        end
    end

    typedef struct packed {
        logic       rst_n;
        logic [2:0] req;
        logic [4:0] pat1;
        logic [2:0] grant;
        logic [4:0] leds;
        logic       busy;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 3'b000;
        step();
        reset = 1'b1;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        bm_cnt   = 0;
        bm_phase = 1'b1;
        bm_used  = 1'b1;
        reset    = 1'b0;
        req      = 3'b000;
        pat0     = 5'h03;
        pat1     = 5'h0A;
        pat2     = 5'h11;
        blink_en = 3'b000;

        //          rst   req     pat1   grant   leds   busy
        vecs[0]  = '{1'b0, 3'b000, 5'h0A, 3'b000, 5'h00, 1'b0}; // reset
        vecs[1]  = '{1'b1, 3'b011, 5'h0A, 3'b010, 5'h0A, 1'b1}; // simultaneous -> 1
        vecs[2]  = '{1'b1, 3'b011, 5'h0A, 3'b010, 5'h0A, 1'b1};
        vecs[3]  = '{1'b1, 3'b001, 5'h0A, 3'b000, 5'h00, 1'b0}; // GAP
        vecs[4]  = '{1'b1, 3'b001, 5'h0A, 3'b000, 5'h00, 1'b0}; // IDLE
        vecs[5]  = '{1'b1, 3'b001, 5'h0A, 3'b001, 5'h03, 1'b1}; // owner 0
        vecs[6]  = '{1'b1, 3'b001, 5'h0A, 3'b001, 5'h03, 1'b1};
        vecs[7]  = '{1'b1, 3'b000, 5'h0A, 3'b000, 5'h00, 1'b0}; // GAP
        vecs[8]  = '{1'b1, 3'b000, 5'h0A, 3'b000, 5'h00, 1'b0}; // IDLE
        vecs[9]  = '{1'b1, 3'b100, 5'h0A, 3'b100, 5'h11, 1'b1}; // owner 2
        vecs[10] = '{1'b1, 3'b000, 5'h0A, 3'b000, 5'h00, 1'b0}; // GAP
        vecs[11] = '{1'b1, 3'b010, 5'h15, 3'b000, 5'h00, 1'b0}; // IDLE
        vecs[12] = '{1'b1, 3'b010, 5'h15, 3'b010, 5'h15, 1'b1}; // owner 1
        vecs[13] = '{1'b0, 3'b010, 5'h15, 3'b000, 5'h00, 1'b0}; // reset mid-OWN
        vecs[14] = '{1'b1, 3'b010, 5'h15, 3'b010, 5'h15, 1'b1}; // re-grant
        vecs[15] = '{1'b1, 3'b010, 5'h1A, 3'b010, 5'h1A, 1'b1}; // live pattern

        for (int i = 0; i < 16; i++) begin
            reset = vecs[i].rst_n;
            req   = vecs[i].req;
            pat1  = vecs[i].pat1;
            step();
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d_leds", i),  32'(leds),  32'(vecs[i].leds));
            check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
            check($sformatf("vec%0d_onehot", i), 32'($onehot0(grant)), 32'd1);
        end

        // Preemption held off until hold_cnt reaches 7, then no dark cycle.
        pat1 = 5'h0A;
        do_reset();
        req = 3'b001;
        step();
        check("pre_grant0", 32'(grant), 32'(3'b001));
        for (int k = 1; k <= 7; k++) begin
            if (k == 2) req = 3'b101;
            step();
            check($sformatf("pre_hold%0d", k), 32'(grant), 32'(3'b001));
        end
        req = 3'b101;
        step();
        check("pre_switch_grant", 32'(grant), 32'(3'b100));
        check("pre_switch_leds",  32'(leds),  32'(5'h11));
        check("pre_switch_busy",  32'(busy),  32'(1'b1));

        // Lower priority never preempts.
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("lowprio%0d", k), 32'(grant), 32'(3'b100));
        end

        // Drop and higher request in the same cycle: GAP, IDLE, then new owner.
        do_reset();
        req = 3'b001;
        step();
        for (int k = 0; k < 10; k++) step();
        check("dvp_owner0", 32'(grant), 32'(3'b001));
        req = 3'b010;
        step();
        check("dvp_gap_grant", 32'(grant), 32'(3'b000));
        check("dvp_gap_leds",  32'(leds),  32'(5'h00));
        step();
        check("dvp_idle_grant", 32'(grant), 32'(3'b000));
        step();
        check("dvp_new_grant", 32'(grant), 32'(3'b010));
        check("dvp_new_leds",  32'(leds),  32'(5'h0A));

        // Blink: runs of four on, four off, aligned to reset of the prescaler.
        pat1 = 5'h1F;
        blink_en = 3'b010;
        do_reset();
        req = 3'b010;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("blink%0d", k), 32'(leds), bm_used ? 32'h1F : 32'h00);
            // Hand-computed: cycles 0-3 and 8-11 lit.
            check($sformatf("blink_abs%0d", k), 32'(leds), ((k / 4) % 2 == 0) ? 32'h1F : 32'h00);
        end
        blink_en = 3'b000;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("noblink%0d", k), 32'(leds), 32'h1F);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the 5-LED bank between three requesters: 2 = alarm, 1 = status, 0 = user pattern.
- Grants the bank by fixed priority.
- Enforces a minimum ownership time before a higher-priority requester can preempt the owner.
- Applies optional per-requester blinking. Drives the board LED pins directly.

Parameters:
- LED_W, 5: width of the LED bank and of each pattern input.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period. Legal range is ≥1.
- HOLD_CYC, 1024: minimum clk cycles the owner keeps the bank before preemption. Legal range is ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  3  request per requester, level-sensitive; bit 2 has the highest priority.
- pat0  in  LED_W  LED pattern of requester 0.
- pat1  in  LED_W  LED pattern of requester 1.
- pat2  in  LED_W  LED pattern of requester 2.
- blink_en  in  3  per-requester blink enable.
- grant  out  3  one-hot current owner; 0 when no owner.
- leds  out  LED_W  registered LED drive.
- busy  out  1  high while in OWN.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, grant=0, leds=0, busy=0.
  - hold_cnt=0, blink_cnt=0, blink_phase=1 (LEDs on).
  - Reset overrides everything, including an active OWN; the bank is released that cycle.
- Blink prescaler:
  - blink_cnt counts 0..BLINK_DIV-1 and wraps.
  - blink_phase toggles on each wrap.
  - Free-running, independent of the FSM; cleared only by reset.
- IDLE:
  - grant=0, leds=0, busy=0.
  - If req≠0, latch owner = highest set bit, clear hold_cnt, go to OWN.
  - grant and leds become valid on the next edge. Latency from req sample to grant is 1 cycle.
- OWN:
  - grant=onehot(owner), busy=1.
  - leds <= (blink_en[owner] && !blink_phase) ? 0 : pat[owner].
  - Patterns are live; a pattern change is visible on leds 1 cycle later.
  - hold_cnt increments while below HOLD_CYC-1, then saturates.
  - Owner drops (req[owner]==0): go to GAP. The drop has priority over preemption in the same cycle.
  - Preemption: higher-priority req set and hold_cnt==HOLD_CYC-1.
    - Go directly to OWN with the new owner.
    - hold_cnt restarts at 0.
    - There is no gap cycle.
  - A higher-priority req before hold expires waits; it is not queued, only re-evaluated each cycle.
  - Lower-priority reqs never preempt.
- GAP:
  - Lasts exactly one cycle: grant=0, leds=0, busy=0.
  - Then IDLE, which re-arbitrates on the following cycle.
  - Guarantees at least one dark cycle between owners after a voluntary release.
- Boundary conditions:
  - Simultaneous reqs in IDLE: highest index wins.
  - HOLD_CYC=1: preemption is possible on the first OWN cycle after grant.
  - BLINK_DIV=1: phase toggles every cycle.
  - req pulses shorter than one cycle are sampled only at edges; a pulse missed between edges is ignored.
  - grant is always one-hot or zero; no other values are legal.

Decomposition:
- Package led_pkg:
  - LED_W constant.
  - State enum {IDLE, OWN, GAP}.
  - Requester index constants REQ_USER=0, REQ_STATUS=1, REQ_ALARM=2.
  - Function prio_enc(3-bit) returning a 2-bit index.
- Sub-module blink_prescaler (parameter BLINK_DIV; ports clk, reset, phase).
  - Reusable by other indicator blocks.
- Arbiter FSM and output mux stay in the top module.

Test Plan (BLINK_DIV=4, HOLD_CYC=8, blink_en=0 unless stated):
- Reset mid-OWN:
  - Stimulus: owner 1, pat1=5'h15, pull reset low for 1 cycle.
  - Required: next edge grant=0, leds=0, busy=0. With req[1] still high, re-grant occurs 1 cycle after reset releases.
- Simultaneous requests:
  - Stimulus: req=3'b011 in IDLE, pat1=5'h0A.
  - Required: 1 cycle later grant=3'b010, leds=5'h0A.
  - Drop req[1]: next cycle GAP (leds=0), then IDLE; the cycle after, grant=3'b001.
- Preemption held off:
  - Stimulus: owner 0; assert req[2] 2 cycles after grant.
  - Required: grant stays 3'b001 until hold_cnt reaches 7, then next cycle grant=3'b100 with leds=pat2. No zero cycle.
- Lower priority ignored:
  - Stimulus: owner 2 held 20 cycles; req[0] high throughout.
  - Required: grant stays 3'b100.
- Blink:
  - Stimulus: owner 1, blink_en[1]=1, pat1=5'h1F.
  - Required: leds alternate 5'h1F/5'h00 in runs of 4 cycles aligned to the free-running prescaler.
  - With blink_en[1]=0, leds stay constant at 5'h1F.
- Drop vs preempt same cycle:
  - Stimulus: owner 0 past hold; req[0] falls in the same cycle req[1] rises.
  - Required: GAP cycle (leds=0), IDLE, then grant=3'b010.
